// File: rtl/tcam_pkg.sv
// Shared geometry constants, row type and byte-merge helper for the 7-bit-key TCAM slice.
package tcam_pkg;

    localparam int TCAM_ROWS    = 128;
    localparam int TCAM_ROW_W   = 64;
    localparam int TCAM_ADDR_W  = 8;
    localparam int TCAM_KEY_W   = 7;
    localparam int TCAM_WDATA_W = 32;
    localparam int TCAM_WMASK_W = 4;

    typedef logic [TCAM_ROW_W-1:0] tcam_row_t;

    // Replace only the bytes of old_word whose mask bit is set.
    function automatic logic [TCAM_WDATA_W-1:0] byte_merge(
        input logic [TCAM_WDATA_W-1:0] old_word,
        input logic [TCAM_WDATA_W-1:0] new_word,
        input logic [TCAM_WMASK_W-1:0] mask
    );
        logic [TCAM_WDATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < TCAM_WMASK_W; b++) begin
            if (mask[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/tcam_half_bank.sv
// 128 x 32 storage for one half of the match vector: byte-masked write, registered read.
module tcam_half_bank
    import tcam_pkg::*;
(
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_we,
    input  logic                    in_re,
    input  logic [TCAM_KEY_W-1:0]   in_row,
    input  logic [TCAM_WMASK_W-1:0] in_wmask,
    input  logic [TCAM_WDATA_W-1:0] in_wdata,
    output logic [TCAM_WDATA_W-1:0] out_rdata
);

    logic [TCAM_WDATA_W-1:0] r_mem [TCAM_ROWS];
    logic [TCAM_WDATA_W-1:0] r_rdata;

    // NOTE: the array is built from resettable flops rather than an SRAM macro,
    // because after reset every row must read as "no entry matches".
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            for (int i = 0; i < TCAM_ROWS; i++) r_mem[i] <= '0;
        end else if (in_we) begin
            // NOTE: non-blocking so the read port in this edge sees the pre-write row.
            r_mem[in_row] <= byte_merge(r_mem[in_row], in_wdata, in_wmask);
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_rdata <= '0;
        end else if (in_re) begin
            r_rdata <= r_mem[in_row];
        end
    end

    assign out_rdata = r_rdata;

endmodule

// File: rtl/tcam_7x64.sv
// TCAM slice top: two half banks, addr[7] selects the written half, search returns {high, low}.
// Optional access trace compiled in with `define TCAM7X64_DEBUG_EN.
module tcam_7x64
    import tcam_pkg::*;
(
    input  logic                    in_clk,
    input  logic                    in_rst,
    input  logic                    in_csb,
    input  logic                    in_web,
    input  logic [TCAM_WMASK_W-1:0] in_wmask,
    input  logic [TCAM_ADDR_W-1:0]  in_addr,
    input  logic [TCAM_WDATA_W-1:0] in_wdata,
    output tcam_row_t               out_rdata
);

    logic                    w_write;
    logic                    w_search;
    logic                    w_we_lo;
    logic                    w_we_hi;
    logic [TCAM_KEY_W-1:0]   w_row;
    logic [TCAM_WDATA_W-1:0] w_rdata_lo;
    logic [TCAM_WDATA_W-1:0] w_rdata_hi;

    assign w_write  = !in_csb && !in_web;
    assign w_search = !in_csb &&  in_web;
    assign w_we_lo  = w_write && !in_addr[TCAM_ADDR_W-1];
    assign w_we_hi  = w_write &&  in_addr[TCAM_ADDR_W-1];
    // Searches ignore addr[7], so both banks read the same row.
    assign w_row    = in_addr[TCAM_KEY_W-1:0];

    tcam_half_bank u_bank_lo (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_we     (w_we_lo),
        .in_re     (w_search),
        .in_row    (w_row),
        .in_wmask  (in_wmask),
        .in_wdata  (in_wdata),
        .out_rdata (w_rdata_lo)
    );

    tcam_half_bank u_bank_hi (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_we     (w_we_hi),
        .in_re     (w_search),
        .in_row    (w_row),
        .in_wmask  (in_wmask),
        .in_wdata  (in_wdata),
        .out_rdata (w_rdata_hi)
    );

    assign out_rdata = {w_rdata_hi, w_rdata_lo};

`ifdef TCAM7X64_DEBUG_EN
    logic                    r_dbg_valid;
    logic                    r_dbg_write;
    logic [TCAM_ADDR_W-1:0]  r_dbg_addr;
    logic [TCAM_WMASK_W-1:0] r_dbg_wmask;
    logic [TCAM_WDATA_W-1:0] r_dbg_wdata;

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            r_dbg_valid <= 1'b0;
            r_dbg_write <= 1'b0;
            r_dbg_addr  <= '0;
            r_dbg_wmask <= '0;
            r_dbg_wdata <= '0;
        end else begin
            r_dbg_valid <= !in_csb;
            r_dbg_write <= !in_web;
            r_dbg_addr  <= in_addr;
            r_dbg_wmask <= in_wmask;
            r_dbg_wdata <= in_wdata;
        end
    end

    // Printed half a cycle after the access edge so out_rdata shows its result.
    always @(negedge in_clk) begin
        if (r_dbg_valid)
            $display("[tcam_7x64] %s addr=%02h wmask=%1h wdata=%08h rdata=%016h",
                     r_dbg_write ? "write " : "search", r_dbg_addr, r_dbg_wmask,
                     r_dbg_wdata, out_rdata);
    end
`endif

endmodule

// File: tb/tb_tcam_7x64.sv
// Directed self-checking bench for tcam_7x64 with hand-computed expected vectors.
module tb_tcam_7x64;

    logic        in_clk;
    logic        in_rst;
    logic        in_csb;
    logic        in_web;
    logic [3:0]  in_wmask;
    logic [7:0]  in_addr;
    logic [31:0] in_wdata;
    logic [63:0] out_rdata;

    int n_tests;
    int n_fail;

    tcam_7x64 dut (
        .in_clk    (in_clk),
        .in_rst    (in_rst),
        .in_csb    (in_csb),
        .in_web    (in_web),
        .in_wmask  (in_wmask),
        .in_addr   (in_addr),
        .in_wdata  (in_wdata),
        .out_rdata (out_rdata)
    );

    initial in_clk = 1'b0;
    always #5 in_clk = ~in_clk;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_tests++;
        assert (observed === expected)
        else begin
            n_fail++;
            $error("FAIL %s: observed %016h expected %016h", tag, observed, expected);
        end
    endtask

    // Each access drives inputs just after a rising edge and samples 1 time unit after the next.
    task automatic cycle_end();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] addr, input logic [3:0] mask, input logic [31:0] data);
        in_csb = 1'b0; in_web = 1'b0; in_addr = addr; in_wmask = mask; in_wdata = data;
        cycle_end();
        in_csb = 1'b1; in_web = 1'b1;
    endtask

    task automatic do_search(input logic [7:0] addr);
        in_csb = 1'b0; in_web = 1'b1; in_addr = addr; in_wmask = 4'h0; in_wdata = 32'h0;
        cycle_end();
        in_csb = 1'b1;
    endtask

    task automatic do_idle();
        in_csb = 1'b1; in_web = 1'b1; in_addr = 8'hFF; in_wmask = 4'hF; in_wdata = 32'hFFFF_FFFF;
        cycle_end();
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        in_rst   = 1'b1;
        in_csb   = 1'b1;
        in_web   = 1'b1;
        in_wmask = 4'h0;
        in_addr  = 8'h00;
        in_wdata = 32'h0;

        repeat (2) @(posedge in_clk);
        #1;
        check("reset_out", out_rdata, 64'h0);
        @(negedge in_clk);
        in_rst = 1'b0;
        cycle_end();

        // Empty array: every search misses
        do_search(8'h00); check("rst_row00", out_rdata, 64'h0);
        do_search(8'h3F); check("rst_row3f", out_rdata, 64'h0);
        do_search(8'h7F); check("rst_row7f", out_rdata, 64'h0);

        // Full low and high halves of row 0x05
        do_write(8'h05, 4'hF, 32'hDEAD_BEEF);
        do_write(8'h85, 4'hF, 32'h1234_5678);
        do_search(8'h05); check("full_row05", out_rdata, 64'h1234_5678_DEAD_BEEF);

        // Only byte 1 of the low half changes
        do_write(8'h05, 4'h2, 32'h0000_AA00);
        do_search(8'h05); check("partial_b1", out_rdata, 64'h1234_5678_DEAD_AAEF);

        // Output holds across a write (wmask 0 no-op) and an idle cycle
        do_write(8'h05, 4'h0, 32'hFFFF_FFFF); check("hold_write", out_rdata, 64'h1234_5678_DEAD_AAEF);
        do_idle();                            check("hold_idle",  out_rdata, 64'h1234_5678_DEAD_AAEF);
        do_search(8'h05); check("wmask0_noop", out_rdata, 64'h1234_5678_DEAD_AAEF);

        // Byte 3 of the high half; search with addr[7]=1 aliases to the same row
        do_write(8'h85, 4'h8, 32'hAB00_0000);
        do_search(8'h85); check("hi_b3_alias", out_rdata, 64'hAB34_5678_DEAD_AAEF);

        // Back-to-back write then search of the last row; neighbour untouched
        do_write(8'h7F, 4'hF, 32'h0000_0001);
        do_search(8'h7F); check("b2b_row7f", out_rdata, 64'h0000_0000_0000_0001);
        do_search(8'h7E); check("row7e_zero", out_rdata, 64'h0);
        do_search(8'h05); check("row05_kept", out_rdata, 64'hAB34_5678_DEAD_AAEF);

        // Asynchronous reset between edges clears the output at once
        #3;
        in_rst = 1'b1;
        #1;
        check("async_rst", out_rdata, 64'h0);
        @(negedge in_clk);
        in_rst = 1'b0;
        cycle_end();
        do_search(8'h05); check("post_rst_05", out_rdata, 64'h0);
        do_search(8'h7F); check("post_rst_7f", out_rdata, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tcam_7x64.md
# tcam_7x64

SRAM-based TCAM slice for one 7-bit key field. It holds 128 rows × 64 bits. Row *k* holds the match vector for key value *k*: bit *e* = 1 means entry *e* matches when this field equals *k*. The parent wrapper instantiates four slices, ANDs their 64-bit outputs with `and_gate`, and encodes the result with `priority_encoder_64x6`. This block implements the `tcam7x64` storage and search path only.

## Interface
- No parameters. Fixed geometry: 128 rows, 64-bit row, 32-bit write port.
- `in_clk` input 1: sole clock; all state is updated on the rising edge.
- `in_rst` input 1: asynchronous, active-high reset.
- `in_csb` input 1: chip select, active low; 1 = idle.
- `in_web` input 1: write enable, active low; 0 = write, 1 = search.
- `in_wmask` input 4: per-byte write enable; bit *i* → `in_wdata[8i+7:8i]`.
- `in_addr` input 8: search uses [6:0] as the key and ignores [7]; write uses [7] as half-select and [6:0] as the row.
- `in_wdata` input 32: write data.
- `out_rdata` output 64: registered match vector of the last search.

## Operation
- Storage: 128 × 64-bit array, split into a low half (bits [31:0]) and a high half (bits [63:32]).
- Write (`in_csb`=0, `in_web`=0): row `in_addr[6:0]`, half selected by `in_addr[7]` (0 = low, 1 = high). Each byte *i* is updated only where `in_wmask[i]`=1; other bytes and the other half keep their value. `out_rdata` holds its value.
- Search (`in_csb`=0, `in_web`=1): `out_rdata` ← full 64-bit row `in_addr[6:0]`.
- Idle (`in_csb`=1): no array change; `out_rdata` holds.
- `in_wmask`=0 during a write is a legal no-op.
- The parent drives a search address of {0, key}. A search with `in_addr[7]`=1 returns the same row as with [7]=0.

## Timing
- Reset (asynchronous assert, synchronous release): every array row and `out_rdata` clear to 0, so every search misses.
- Search latency is 1 cycle: the address is presented in cycle N and the data is valid after edge N, i.e. in cycle N+1, then held until the next search or reset.
- Write takes effect at the edge. A search of the same row in the next cycle returns the new data; there is no bypass within the same cycle, because reads and writes are exclusive.
- A reset asserted mid-operation aborts any access; the array and output read 0 immediately.
- No handshake. An access can be issued every cycle.

## Configuration
- `TCAM7X64_DEBUG_EN`: when defined, each selected access (`in_csb`=0) prints via `$display` the op (write/search), address, wmask, wdata and the resulting `out_rdata`. When undefined, no display code is compiled. Functional behaviour is identical either way.

## Structure
- Shared package `tcam_pkg`:
  - constants `TCAM_ROWS`=128, `TCAM_ROW_W`=64, `TCAM_ADDR_W`=8, `TCAM_KEY_W`=7, `TCAM_WDATA_W`=32, `TCAM_WMASK_W`=4;
  - typedef `tcam_row_t` (logic [63:0]).
- One natural sub-module, `tcam_half_bank`: 128 × 32 storage with byte-masked write and registered read, with the same clock and reset. It is instantiated twice (low and high half). The top level decodes `in_addr[7]` to gate each bank's write enable and concatenates the two read outputs as {high, low}.

## Test plan
- Reset → search rows 0x00, 0x3F and 0x7F → `out_rdata` = 0 each time, one cycle after the search.
- Write row 0x05 low half (addr 0x05, wmask 0xF, data 0xDEADBEEF), then high half (addr 0x85, data 0x12345678) → search addr 0x05 → 0x12345678DEADBEEF.
- Partial mask: on row 0x05 from the previous test, write addr 0x05, wmask 0x2, data 0x0000AA00 → search → 0x12345678DEADAAEF.
- Hold: after a search returning a value, issue a write cycle and then an idle cycle (`in_csb`=1) → `out_rdata` unchanged in both.
- Back-to-back: write row 0x7F low = 0x00000001, then search 0x7F in the next cycle → 0x0000000000000001. Row 0x7E remains 0.
- Asynchronous reset mid-stream: assert `in_rst` between edges after loading data → `out_rdata` goes to 0 immediately; a search of row 0x05 after release → 0.
